// File: rtl/rf_scoreboard_pkg.sv
// Shared core definitions for the parametrised register file: default sizes,
// the register-index type and the hardwired-zero register number.
package rf_scoreboard_pkg;

   localparam int XLEN_DEF = 32;
   localparam int NREG_DEF = 32;
   localparam int NRD_DEF  = 2;

   typedef logic [$clog2(NREG_DEF)-1:0] reg_idx_t;

   localparam int unsigned X0 = 0;

endpackage

// File: rtl/rf_scoreboard_if.sv
// Decode/write-back side bundle of the register file.
// The master is the pipeline; the slave is the register file itself.
interface rf_scoreboard_if #(
   parameter int XLEN = 32,
   parameter int NREG = 32,
   parameter int NRD  = 2
);
   localparam int AW = $clog2(NREG);

   logic [NRD*AW-1:0]   rd_addr;
   logic [NRD*XLEN-1:0] rd_data;
   logic [NRD-1:0]      rd_busy;
   logic                wr_en;
   logic [AW-1:0]       wr_addr;
   logic [XLEN-1:0]     wr_data;
   logic                iss_en;
   logic [AW-1:0]       iss_addr;
   logic [AW:0]         pend_cnt;
   logic                any_busy;

   modport master (
      output rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
      input  rd_data, rd_busy, pend_cnt, any_busy
   );

   modport slave (
      input  rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
      output rd_data, rd_busy, pend_cnt, any_busy
   );

endinterface

// File: rtl/rf_scoreboard_rdport.sv
// One combinational read port: write-back forwarding, x0 gating and the
// read-after-write busy flag for the addressed source register.
module rf_read_port
   import rf_scoreboard_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int AW   = 5
)(
   input  logic [AW-1:0]   i_rdAddr,
   input  logic            i_wrEn,
   input  logic [AW-1:0]   i_wrAddr,
   input  logic [XLEN-1:0] i_wrData,
   input  logic [XLEN-1:0] i_regData,
   input  logic            i_pend,
   output logic [XLEN-1:0] o_rdData,
   output logic            o_rdBusy
);

   logic w_isX0;
   logic w_fwdHit;

   assign w_isX0   = (i_rdAddr == AW'(X0));
   assign w_fwdHit = i_wrEn && (i_wrAddr == i_rdAddr);

   // A write-back landing this cycle both supplies the value and resolves the hazard.
   assign o_rdData = w_isX0   ? '0 :
                     w_fwdHit ? i_wrData : i_regData;
   assign o_rdBusy = i_pend && !w_isX0 && !w_fwdHit;

endmodule

// File: rtl/rf_scoreboard.sv
// Parametrised integer register file with write-to-read forwarding and a
// per-register pending scoreboard used by decode to stall on RAW hazards.
module rf_scoreboard
   import rf_scoreboard_pkg::*;
#(
   parameter int XLEN = XLEN_DEF,
   parameter int NREG = NREG_DEF,
   parameter int NRD  = NRD_DEF
)(
   input  logic           clk,
   input  logic           rst,
   rf_scoreboard_if.slave bus
);

   localparam int AW = $clog2(NREG);
   localparam int CW = AW + 1;

   logic [XLEN-1:0]     r_regs [NREG];
   logic [NREG-1:0]     r_pend;
   logic [CW-1:0]       r_pendCnt;

   logic                w_wrValid;
   logic                w_issValid;
   logic                w_fwdEn;
   logic                w_setPend;
   logic                w_clrPend;
   logic [NREG-1:0]     w_pendNext;
   logic [NRD-1:0]      w_rdBusy;
   logic [NRD*XLEN-1:0] w_rdData;

   assign w_wrValid  = bus.wr_en  && (bus.wr_addr  != AW'(X0));
   assign w_issValid = bus.iss_en && (bus.iss_addr != AW'(X0));
   // Forwarding is suppressed in reset so every read port reads zero while rst is low.
   assign w_fwdEn    = bus.wr_en && rst;

   // Issue is applied after write-back so a same-register pair leaves the newer producer pending.
   always_comb begin
      w_pendNext = r_pend;
      if (w_wrValid)  w_pendNext[bus.wr_addr]  = 1'b0;
      if (w_issValid) w_pendNext[bus.iss_addr] = 1'b1;
   end

   assign w_setPend = w_issValid && !r_pend[bus.iss_addr];
   assign w_clrPend = w_wrValid && r_pend[bus.wr_addr] &&
                      !(w_issValid && (bus.iss_addr == bus.wr_addr));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
      end else if (w_wrValid) begin
         r_regs[bus.wr_addr] <= bus.wr_data;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_pend    <= '0;
         r_pendCnt <= '0;
      end else begin
         r_pend    <= w_pendNext;
         r_pendCnt <= r_pendCnt + CW'(w_setPend) - CW'(w_clrPend);
      end
   end

   for (genvar g = 0; g < NRD; g++) begin : g_port
      logic [AW-1:0] w_rdAddr;
      assign w_rdAddr = bus.rd_addr[g*AW +: AW];

      rf_read_port #(
         .XLEN (XLEN),
         .AW   (AW)
      ) u_port (
         .i_rdAddr  (w_rdAddr),
         .i_wrEn    (w_fwdEn),
         .i_wrAddr  (bus.wr_addr),
         .i_wrData  (bus.wr_data),
         .i_regData (r_regs[w_rdAddr]),
         .i_pend    (r_pend[w_rdAddr]),
         .o_rdData  (w_rdData[g*XLEN +: XLEN]),
         .o_rdBusy  (w_rdBusy[g])
      );
   end

   assign bus.rd_data  = w_rdData;
   assign bus.rd_busy  = w_rdBusy;
   assign bus.any_busy = |w_rdBusy;
   assign bus.pend_cnt = r_pendCnt;

endmodule

// File: tb/tb_rf_scoreboard.sv
// Directed checks on the default 32x32/2-port file, then a 64-bit, 16-register,
// 3-port instance exercised with random traffic against a reference model.
module tb_rf_scoreboard;

   logic clk;
   logic rstN;
   int   testsRun;
   int   testsFailed;

   logic [63:0] mRegs [16];
   logic [15:0] mPend;

   rf_scoreboard_if #(.XLEN(32), .NREG(32), .NRD(2)) bus0 ();
   rf_scoreboard_if #(.XLEN(64), .NREG(16), .NRD(3)) bus1 ();

   rf_scoreboard #(.XLEN(32), .NREG(32), .NRD(2)) dut0 (
      .clk (clk),
      .rst (rstN),
      .bus (bus0)
   );

   rf_scoreboard #(.XLEN(64), .NREG(16), .NRD(3)) dut1 (
      .clk (clk),
      .rst (rstN),
      .bus (bus1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      testsRun++;
      assert (obs === exp) else begin
         testsFailed++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Drives one cycle of inputs on the small instance at the falling edge, then settles.
   task automatic applyStimulus(input logic wrEn, input logic [4:0] wrAddr, input logic [31:0] wrData,
                                input logic issEn, input logic [4:0] issAddr,
                                input logic [4:0] rd0, input logic [4:0] rd1);
      @(negedge clk);
      bus0.wr_en    = wrEn;
      bus0.wr_addr  = wrAddr;
      bus0.wr_data  = wrData;
      bus0.iss_en   = issEn;
      bus0.iss_addr = issAddr;
      bus0.rd_addr  = {rd1, rd0};
      #1;
   endtask

   initial begin
      testsRun    = 0;
      testsFailed = 0;
      rstN        = 1'b0;
      bus0.wr_en = 1'b0; bus0.wr_addr = '0; bus0.wr_data = '0;
      bus0.iss_en = 1'b0; bus0.iss_addr = '0; bus0.rd_addr = '0;
      bus1.wr_en = 1'b0; bus1.wr_addr = '0; bus1.wr_data = '0;
      bus1.iss_en = 1'b0; bus1.iss_addr = '0; bus1.rd_addr = '0;

      applyStimulus(1, 7, 32'h1111_2222, 0, 0, 0, 7);
      checkOutput("rst_fwd_data", 64'(bus0.rd_data[63:32]), 64'h0);
      checkOutput("rst_cnt",      64'(bus0.pend_cnt), 64'h0);
      checkOutput("rst_any_busy", 64'(bus0.any_busy), 64'h0);

      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      rstN = 1'b1;

      applyStimulus(1, 7, 32'hDEAD_BEEF, 0, 0, 0, 7);
      checkOutput("fwd_data", 64'(bus0.rd_data[63:32]), 64'hDEAD_BEEF);
      checkOutput("fwd_busy", 64'(bus0.rd_busy[1]), 64'h0);
      applyStimulus(0, 0, 0, 0, 0, 0, 7);
      checkOutput("fwd_stored", 64'(bus0.rd_data[63:32]), 64'hDEAD_BEEF);

      applyStimulus(1, 0, 32'hFFFF_FFFF, 1, 0, 0, 0);
      checkOutput("x0_fwd_data", 64'(bus0.rd_data[31:0]), 64'h0);
      checkOutput("x0_any_busy", 64'(bus0.any_busy), 64'h0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      checkOutput("x0_data", 64'(bus0.rd_data[31:0]), 64'h0);
      checkOutput("x0_cnt",  64'(bus0.pend_cnt), 64'h0);
      checkOutput("x0_busy", 64'(bus0.rd_busy), 64'h0);

      applyStimulus(0, 0, 0, 1, 3, 3, 0);
      checkOutput("sb_issue_busy", 64'(bus0.rd_busy[0]), 64'h0);
      checkOutput("sb_issue_cnt",  64'(bus0.pend_cnt), 64'h0);
      applyStimulus(0, 0, 0, 0, 0, 3, 0);
      checkOutput("sb_busy", 64'(bus0.rd_busy[0]), 64'h1);
      checkOutput("sb_cnt",  64'(bus0.pend_cnt), 64'h1);
      checkOutput("sb_any",  64'(bus0.any_busy), 64'h1);
      applyStimulus(0, 0, 0, 0, 0, 3, 0);
      checkOutput("sb_busy_hold", 64'(bus0.rd_busy[0]), 64'h1);
      applyStimulus(1, 3, 32'h9, 0, 0, 3, 0);
      checkOutput("sb_wb_busy", 64'(bus0.rd_busy[0]), 64'h0);
      checkOutput("sb_wb_data", 64'(bus0.rd_data[31:0]), 64'h9);
      checkOutput("sb_wb_cnt",  64'(bus0.pend_cnt), 64'h1);
      applyStimulus(0, 0, 0, 0, 0, 3, 0);
      checkOutput("sb_after_cnt",  64'(bus0.pend_cnt), 64'h0);
      checkOutput("sb_after_data", 64'(bus0.rd_data[31:0]), 64'h9);

      applyStimulus(0, 0, 0, 1, 4, 4, 0);
      applyStimulus(1, 4, 32'h55, 1, 4, 4, 0);
      checkOutput("sim_cnt_before", 64'(bus0.pend_cnt), 64'h1);
      checkOutput("sim_fwd",        64'(bus0.rd_data[31:0]), 64'h55);
      checkOutput("sim_fwd_busy",   64'(bus0.rd_busy[0]), 64'h0);
      applyStimulus(0, 0, 0, 0, 0, 4, 0);
      checkOutput("sim_data", 64'(bus0.rd_data[31:0]), 64'h55);
      checkOutput("sim_busy", 64'(bus0.rd_busy[0]), 64'h1);
      checkOutput("sim_cnt",  64'(bus0.pend_cnt), 64'h1);

      applyStimulus(0, 0, 0, 1, 4, 4, 0);
      applyStimulus(1, 4, 32'h66, 1, 8, 8, 4);
      checkOutput("dbl_cnt",      64'(bus0.pend_cnt), 64'h1);
      checkOutput("diff_x8_busy", 64'(bus0.rd_busy[0]), 64'h0);
      checkOutput("diff_x4_fwd",  64'(bus0.rd_data[63:32]), 64'h66);
      applyStimulus(0, 0, 0, 0, 0, 8, 4);
      checkOutput("diff_cnt",      64'(bus0.pend_cnt), 64'h1);
      checkOutput("diff_x8_busy2", 64'(bus0.rd_busy[0]), 64'h1);
      checkOutput("diff_x4_busy",  64'(bus0.rd_busy[1]), 64'h0);
      checkOutput("diff_x4_data",  64'(bus0.rd_data[63:32]), 64'h66);

      applyStimulus(1, 10, 32'hA, 0, 0, 10, 8);
      checkOutput("nopend_fwd", 64'(bus0.rd_data[31:0]), 64'hA);
      applyStimulus(0, 0, 0, 0, 0, 10, 8);
      checkOutput("nopend_data", 64'(bus0.rd_data[31:0]), 64'hA);
      checkOutput("nopend_cnt",  64'(bus0.pend_cnt), 64'h1);
      checkOutput("nopend_x8",   64'(bus0.rd_busy[1]), 64'h1);

      applyStimulus(1, 5, 32'h1234, 1, 6, 5, 6);
      applyStimulus(0, 0, 0, 0, 0, 5, 6);
      checkOutput("mid_data", 64'(bus0.rd_data[31:0]), 64'h1234);
      checkOutput("mid_busy", 64'(bus0.rd_busy[1]), 64'h1);
      checkOutput("mid_cnt",  64'(bus0.pend_cnt), 64'h2);
      rstN = 1'b0;
      #1;
      checkOutput("rst_mid_data", 64'(bus0.rd_data[31:0]), 64'h0);
      checkOutput("rst_mid_busy", 64'(bus0.rd_busy), 64'h0);
      checkOutput("rst_mid_any",  64'(bus0.any_busy), 64'h0);
      checkOutput("rst_mid_cnt",  64'(bus0.pend_cnt), 64'h0);
      applyStimulus(0, 0, 0, 0, 0, 5, 6);
      applyStimulus(1, 5, 32'h77, 0, 0, 5, 6);
      rstN = 1'b1;
      #1;
      checkOutput("post_fwd", 64'(bus0.rd_data[31:0]), 64'h77);
      applyStimulus(0, 0, 0, 0, 0, 5, 8);
      checkOutput("post_data", 64'(bus0.rd_data[31:0]), 64'h77);
      checkOutput("post_busy", 64'(bus0.rd_busy[1]), 64'h0);
      checkOutput("post_cnt",  64'(bus0.pend_cnt), 64'h0);

      // Wide instance: reference model updated after each cycle's checks.
      for (int i = 0; i < 16; i++) mRegs[i] = '0;
      mPend = '0;
      for (int c = 0; c < 300; c++) begin
         @(negedge clk);
         bus1.wr_en    = ($urandom_range(0, 1) == 1);
         bus1.wr_addr  = 4'($urandom_range(0, 15));
         bus1.wr_data  = {$urandom, $urandom};
         bus1.iss_en   = ($urandom_range(0, 2) == 0);
         bus1.iss_addr = 4'($urandom_range(0, 15));
         bus1.rd_addr  = 12'($urandom);
         #1;
         for (int p = 0; p < 3; p++) begin
            logic [3:0]  a;
            logic        hit;
            logic [63:0] expData;
            logic        expBusy;
            a       = bus1.rd_addr[p*4 +: 4];
            hit     = bus1.wr_en && (bus1.wr_addr == a);
            expData = (a == 4'd0) ? 64'h0 : (hit ? bus1.wr_data : mRegs[a]);
            expBusy = (a != 4'd0) && mPend[a] && !hit;
            checkOutput($sformatf("sweep_data c%0d p%0d", c, p), bus1.rd_data[p*64 +: 64], expData);
            checkOutput($sformatf("sweep_busy c%0d p%0d", c, p), 64'(bus1.rd_busy[p]), 64'(expBusy));
         end
         checkOutput($sformatf("sweep_cnt c%0d", c), 64'(bus1.pend_cnt), 64'($countones(mPend)));
         if (bus1.wr_en && bus1.wr_addr != 4'd0) begin
            mRegs[bus1.wr_addr] = bus1.wr_data;
            mPend[bus1.wr_addr] = 1'b0;
         end
         if (bus1.iss_en && bus1.iss_addr != 4'd0) mPend[bus1.iss_addr] = 1'b1;
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
